mem_arbiter: RTL and testbench

Two-port arbiter that shares the single synchronous 8-bit memory between the CPU's memory interface (port 0, driven from MAR, the TO_MEMORY bus and write) and a second master such as a bootloader or DMA (port 1). It serialises transactions, hides the memory's one-cycle read latency behind a req/ack handshake, and alternates priority round-robin. An optional lock keeps one owner on the memory for back-to-back transactions, bounded by a counter.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_select.sv | 21 ++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   arb_state_t : arbiter FSM state encoding (2 bits)
//   PORT_CPU    : port 0, the CPU memory interface
//   PORT_AUX    : port 1, the secondary master (bootloader / DMA)
//   LOCK_CNT_W  : width of the consecutive-locked-transaction counter
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int LOCK_CNT_W = 4;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker for two requesters.
// Ports:
//   req0, req1  : pending requests
//   last_grant  : index of the port granted most recently
//   grant_vld   : at least one request is pending
//   grant_idx   : index of the port to grant (meaningful when grant_vld)
module rr_select (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_idx
);

  assign grant_vld = req0 | req1;

  // A lone requester always wins; on a tie the port that was not served
  // last takes its turn.
  assign grant_idx = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous memory with one cycle
// of read latency. Transactions are serialised, priority alternates
// round-robin, and an optional lock keeps the owner on the memory for a
// bounded number of back-to-back transactions.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*     : per-port request, held until ack
//   lock*                     : keep ownership after the current transaction
//   ack0, ack1                : one-cycle completion pulse
//   rdata                     : last read data, valid in the ack cycle
//   mem_addr/mem_wdata/mem_we : memory command, registered
//   mem_rdata                 : memory read data, one cycle after address
//   owner, busy               : current/last owner, not idle
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  localparam logic [LOCK_CNT_W:0] LOCK_LIMIT = (LOCK_CNT_W+1)'(MAX_LOCK);
  localparam logic [LOCK_CNT_W:0] LOCK_ONE   = (LOCK_CNT_W+1)'(1);

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_W-1:0]     rdata_q;

  logic                  grant_vld, grant_idx;
  logic                  sel_idx, sel_req, sel_we, sel_lock;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  lock_ok, do_load;

  rr_select u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant_vld  (grant_vld),
    .grant_idx  (grant_idx)
  );

  // In S_IDLE the port about to be granted supplies the command; otherwise
  // the current owner does (locked continuation out of S_ACK).
  assign sel_idx   = (state_q == S_IDLE) ? grant_idx : owner_q;
  assign sel_req   = sel_idx ? req1   : req0;
  assign sel_we    = sel_idx ? we1    : we0;
  assign sel_lock  = sel_idx ? lock1  : lock0;
  assign sel_addr  = sel_idx ? addr1  : addr0;
  assign sel_wdata = sel_idx ? wdata1 : wdata0;

  assign lock_cnt_inc = (&lock_cnt_q) ? lock_cnt_q : lock_cnt_q + LOCK_CNT_W'(1);
  assign lock_ok      = ({1'b0, lock_cnt_q} + LOCK_ONE) < LOCK_LIMIT;

  // The memory command is captured on the edge that enters S_ISSUE, so the
  // memory pins come straight from flops and a dropped req cannot disturb
  // a transaction already in flight.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_we_d     = 1'b0;
    do_load      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d      = S_ISSUE;
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          do_load      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (mem_we_q) begin
          state_d = S_ACK;
        end else begin
          state_d    = S_WAIT;
          mem_addr_d = mem_addr_q;
        end
      end
      S_WAIT: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (sel_lock && sel_req && lock_ok) begin
          state_d    = S_ISSUE;
          lock_cnt_d = lock_cnt_inc;
          do_load    = 1'b1;
        end else begin
          state_d    = S_IDLE;
          lock_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_load) begin
      mem_addr_d  = sel_addr;
      mem_we_d    = sel_we;
      mem_wdata_d = sel_we ? sel_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= PORT_CPU;
      last_grant_q <= PORT_AUX;
      lock_cnt_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      // Memory data is valid during S_WAIT; writes never touch rdata.
      if (state_q == S_WAIT) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign ack0      = (state_q == S_ACK) && (owner_q == PORT_CPU);
  assign ack1      = (state_q == S_ACK) && (owner_q == PORT_AUX);
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic       clk, reset;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, mem_we, owner, busy;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: write on the edge, read data one cycle after address.
  logic [7:0] mem [256];
  logic       mem_load;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 8'h5A;
    if (a == 8'h11) return 8'h3C;
    return a * 8'd7 + 8'd3;
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (p == 1) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  // Single transaction on one port; measures latency from the sampling edge.
  task automatic run_txn(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd, output int we_cnt,
                         output bit we_ok, output bit other_ack);
    drive(p, 1'b1, w, a, d);
    lat = -1; rd = 8'h00; we_cnt = 0; we_ok = 1'b1; other_ack = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we === 1'b1) begin
        we_cnt++;
        if (mem_addr !== a || mem_wdata !== d) we_ok = 1'b0;
      end
      if (((p == 1) ? ack0 : ack1) === 1'b1) other_ack = 1'b1;
      if (((p == 1) ? ack1 : ack0) === 1'b1) begin
        lat = c;
        rd  = rdata;
        break;
      end
    end
    @(posedge clk); #1;
    drive(p, 1'b0, w, a, d);
  endtask

  // Both ports request n0/n1 back-to-back transactions; acks are logged.
  int         log_port [16];
  int         log_cyc  [16];
  logic [7:0] log_rd   [16];
  int         n_log;

  task automatic serve(input int n0, input int n1, input bit lk0, input bit lk1, input int budget);
    int r0, r1;
    r0 = n0; r1 = n1; n_log = 0;
    req0 = (r0 > 0); req1 = (r1 > 0);
    lock0 = lk0 && (r0 > 1); lock1 = lk1 && (r1 > 1);
    for (int c = 1; c <= budget && (r0 > 0 || r1 > 0); c++) begin
      @(negedge clk);
      if (ack0 === 1'b1 && r0 > 0 && n_log < 16) begin
        log_port[n_log] = 0; log_cyc[n_log] = c; log_rd[n_log] = rdata; n_log++; r0--;
      end
      if (ack1 === 1'b1 && r1 > 0 && n_log < 16) begin
        log_port[n_log] = 1; log_cyc[n_log] = c; log_rd[n_log] = rdata; n_log++; r1--;
      end
      @(posedge clk); #1;
      req0 = (r0 > 0); req1 = (r1 > 0);
      lock0 = lk0 && (r0 > 1); lock1 = lk1 && (r1 > 1);
    end
    check("serve_done_in_budget", 32'(r0 + r1), 32'd0);
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
  endtask

  // Randomized phase: per-port drivers plus a transaction-level scoreboard.
  logic       cur_we    [2];
  logic [7:0] cur_addr  [2];
  logic [7:0] cur_wdata [2];
  logic [7:0] shadow    [256];
  logic [7:0] last_rd;
  bit         done0, done1;

  task automatic drive_port(input int p, input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      cur_we[p]    = 1'($urandom_range(0, 1));
      cur_addr[p]  = 8'h80 + 8'($urandom_range(0, 7));
      cur_wdata[p] = 8'($urandom);
      drive(p, 1'b1, cur_we[p], cur_addr[p], cur_wdata[p]);
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (((p == 1) ? ack1 : ack0) === 1'b1) got = 1'b1;
      end
      check("rnd_ack_in_budget", 32'(got), 32'd1);
      @(posedge clk); #1;
      drive(p, 1'b0, cur_we[p], cur_addr[p], cur_wdata[p]);
    end
    if (p == 1) done1 = 1'b1; else done0 = 1'b1;
  endtask

  task automatic monitor_rand();
    int         prev_port;
    bit         prev_other;
    logic [7:0] exp;
    prev_port = -1; prev_other = 1'b0;
    for (int c = 0; c < 20000 && !(done0 && done1); c++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) check("rnd_single_ack", 32'(ack0 & ack1), 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (((p == 1) ? ack1 : ack0) === 1'b1) begin
          check("rnd_ack_while_req", 32'((p == 1) ? req1 : req0), 32'd1);
          if (cur_we[p]) begin
            shadow[cur_addr[p]] = cur_wdata[p];
            exp = last_rd;
          end else begin
            exp = shadow[cur_addr[p]];
            last_rd = exp;
          end
          check("rnd_rdata", 32'(rdata), 32'(exp));
          // A port left waiting through another port's ack is served next.
          if (prev_other) check("rnd_round_robin", 32'(p), 32'(1 - prev_port));
          prev_port  = p;
          prev_other = (p == 1) ? req0 : req1;
        end
      end
    end
  endtask

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         lat, we_cnt;
    logic [7:0] rd;
    bit         we_ok, other_ack;

    tbl[0] = '{0, 1'b0, 8'h10, 8'h00, 8'h5A, 3};
    tbl[1] = '{1, 1'b1, 8'h20, 8'hC3, 8'h5A, 2};
    tbl[2] = '{0, 1'b0, 8'h20, 8'h00, 8'hC3, 3};
    tbl[3] = '{1, 1'b0, 8'h11, 8'h00, 8'h3C, 3};
    tbl[4] = '{0, 1'b1, 8'h11, 8'h99, 8'h3C, 2};
    tbl[5] = '{1, 1'b0, 8'h11, 8'h00, 8'h99, 3};
    tbl[6] = '{0, 1'b1, 8'hFF, 8'h00, 8'h99, 2};
    tbl[7] = '{1, 1'b0, 8'hFF, 8'h00, 8'h00, 3};
    tbl[8] = '{0, 1'b0, 8'h00, 8'h00, init_val(8'h00), 3};

    reset = 1'b0; mem_load = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    done0 = 1'b0; done1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({ack0, ack1, rdata, mem_addr, mem_wdata, mem_we, owner, busy}), 32'd0);
    mem_load = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Table of isolated transactions
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, we_cnt, we_ok, other_ack);
      check("vec_latency", 32'(lat), 32'(tbl[i].exp_lat));
      check("vec_rdata", 32'(rd), 32'(tbl[i].exp_rd));
      check("vec_no_other_ack", 32'(other_ack), 32'd0);
      if (tbl[i].we) check("vec_we_pulse", 32'(we_cnt == 1 && we_ok), 32'd1);
      else           check("vec_no_we", 32'(we_cnt), 32'd0);
    end

    // Simultaneous requests right after reset
    reset = 1'b0; #2; reset = 1'b1;
    @(posedge clk); #1;
    we0 = 1'b0; addr0 = 8'h10; we1 = 1'b0; addr1 = 8'h12;
    for (int r = 0; r < 2; r++) begin
      serve(1, 1, 1'b0, 1'b0, 40);
      check("tie_count", 32'(n_log), 32'd2);
      check("tie_first", 32'(log_port[0]), 32'd0);
      check("tie_second", 32'(log_port[1]), 32'd1);
      check("tie_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd4);
    end

    // Lock expiry: port 0 locks for 6 reads while port 1 waits
    addr0 = 8'h40; addr1 = 8'h41;
    serve(6, 1, 1'b1, 1'b0, 80);
    check("lock_count", 32'(n_log), 32'd7);
    for (int k = 0; k < 7; k++) check("lock_order", 32'(log_port[k]), (k == 4) ? 32'd1 : 32'd0);
    for (int k = 0; k < 3; k++) check("lock_b2b", 32'(log_cyc[k+1] - log_cyc[k]), 32'd3);
    check("lock_handover_gap", 32'(log_cyc[4] - log_cyc[3]), 32'd4);

    // Write/read interleave on the same address; port 0 was served last
    we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h11;
    we1 = 1'b0; addr1 = 8'h30;
    serve(1, 1, 1'b0, 1'b0, 40);
    check("ilv1_order", 32'(log_port[0]), 32'd1);
    check("ilv1_read_old", 32'(log_rd[0]), 32'(init_val(8'h30)));
    we1 = 1'b0; addr1 = 8'h31;
    serve(0, 1, 1'b0, 1'b0, 20);
    we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h22;
    we1 = 1'b0; addr1 = 8'h30;
    serve(1, 1, 1'b0, 1'b0, 40);
    check("ilv2_order", 32'(log_port[0]), 32'd0);
    check("ilv2_read_new", 32'(log_rd[1]), 32'h22);

    // Asynchronous reset during S_ISSUE of a write
    drive(0, 1'b1, 1'b1, 8'h50, 8'hEE);
    @(posedge clk); #2;
    check("midwr_we_before", 32'(mem_we), 32'd1);
    reset = 1'b0; #1;
    check("midwr_we_async", 32'(mem_we), 32'd0);
    check("midwr_outputs",
          32'({ack0, ack1, rdata, mem_addr, mem_wdata, mem_we, owner, busy}), 32'd0);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midwr_no_ack", 32'({ack0, ack1}), 32'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midwr_idle_after", 32'({ack0, ack1, busy}), 32'd0);
    end
    check("midwr_mem_kept", 32'(mem[8'h50]), 32'(init_val(8'h50)));
    @(posedge clk); #1;

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    last_rd = 8'h00;
    fork
      drive_port(0, 40);
      drive_port(1, 40);
      monitor_rand();
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
